// File: rtl/imem_loader.sv
// Boot loader that assembles a big-endian byte stream into 32-bit words and writes
// them into instruction memory, holding the CPU in reset until the image is complete.
module imem_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_wordIdx;
    logic [1:0]        r_byteCnt;
    logic [31:0]       r_word;
    logic              r_err;

    logic w_startSeen;
    logic w_lenZero;
    logic w_lenTooBig;
    logic w_accept;
    logic w_lastWord;

    // A start is honoured only while no load is running.
    assign w_startSeen = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_lenZero   = (len == '0);
    assign w_lenTooBig = (len > LEN_MAX);
    assign w_accept    = byte_valid && (r_state == LOAD);
    assign w_lastWord  = ({1'b0, r_wordIdx} == (r_len - LEN_ONE));

    assign wr_addr = BASE + (32'(r_wordIdx) << 2);
    assign wr_data = r_word;
    assign err     = r_err;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        byte_ready  = 1'b0;
        wr_en       = 1'b0;
        cpu_hold    = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startSeen) begin
                    w_stateNext = (w_lenZero || w_lenTooBig) ? DONE : LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && (r_byteCnt == 2'd3)) begin
                    w_stateNext = WRITE;
                end
            end
            WRITE: begin
                wr_en       = 1'b1;
                busy        = 1'b1;
                w_stateNext = w_lastWord ? DONE : LOAD;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (w_startSeen) begin
                    w_stateNext = (w_lenZero || w_lenTooBig) ? DONE : LOAD;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Datapath: length latch, error flag, byte assembly and word index.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_len     <= '0;
            r_wordIdx <= '0;
            r_byteCnt <= 2'd0;
            r_word    <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            if (w_startSeen) begin
                if (w_lenZero) begin
                    r_err <= 1'b0;
                end else if (w_lenTooBig) begin
                    r_err <= 1'b1;
                end else begin
                    r_len     <= len;
                    r_wordIdx <= '0;
                    r_byteCnt <= 2'd0;
                    r_err     <= 1'b0;
                end
            end
            if (w_accept) begin
                case (r_byteCnt)
                    2'd0: r_word[31:24] <= byte_data;
                    2'd1: r_word[23:16] <= byte_data;
                    2'd2: r_word[15:8]  <= byte_data;
                    2'd3: r_word[7:0]   <= byte_data;
                    default: r_word     <= r_word;
                endcase
                r_byteCnt <= r_byteCnt + 2'd1;
            end
            if ((r_state == WRITE) && !w_lastWord) begin
                r_wordIdx <= r_wordIdx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE 0 and BASE FFFFFFFC) share the
// stimulus, and a scoreboard per instance predicts every memory write.
module tb_imem_loader;

    localparam int          ADDR_W = 8;
    localparam logic [31:0] BASE2  = 32'hFFFF_FFFC;

    logic              clk = 1'b0;
    logic              rstN;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              byteValid;
    logic [7:0]        byteData;

    logic        byteReady, wrEn, cpuHold, busy, done, err;
    logic [31:0] wrAddr, wrData;
    logic        byteReady2, wrEn2, cpuHold2, busy2, done2, err2;
    logic [31:0] wrAddr2, wrData2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wrExp_t;

    wrExp_t q1[$];
    wrExp_t q2[$];
    wrExp_t e1;
    wrExp_t e2;
    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .BASE(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rstN), .start(start), .len(len),
        .byte_valid(byteValid), .byte_data(byteData), .byte_ready(byteReady),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .cpu_hold(cpuHold), .busy(busy), .done(done), .err(err)
    );

    imem_loader #(.ADDR_W(ADDR_W), .BASE(BASE2)) dutWrap (
        .clk(clk), .rst_n(rstN), .start(start), .len(len),
        .byte_valid(byteValid), .byte_data(byteData), .byte_ready(byteReady2),
        .wr_en(wrEn2), .wr_addr(wrAddr2), .wr_data(wrData2),
        .cpu_hold(cpuHold2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [ADDR_W:0] l);
        start = s;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic expectWrite(input int idx, input logic [31:0] data);
        q1.push_back('{32'(idx * 4), data});
        q2.push_back('{BASE2 + 32'(idx * 4), data});
    endtask

    // Holds the byte on the bus until the loader takes it, bounded to avoid hanging.
    task automatic sendByte(input logic [7:0] b);
        int waited = 0;
        byteValid = 1'b1;
        byteData  = b;
        while (!byteReady && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("byte_ready before accept", 32'(byteReady), 1);
        tick();
        byteValid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            sendByte(w[31 - 8*i -: 8]);
        end
    endtask

    always @(negedge clk) begin
        if (wrEn === 1'b1) begin
            checkOutput("write expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                checkOutput("wr_addr", wrAddr, e1.addr);
                checkOutput("wr_data", wrData, e1.data);
            end
        end
        if (wrEn2 === 1'b1) begin
            checkOutput("wrap write expected", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                checkOutput("wrap wr_addr", wrAddr2, e2.addr);
                checkOutput("wrap wr_data", wrData2, e2.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b1; start = 1'b0; len = '0; byteValid = 1'b0; byteData = 8'h00;
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("reset byte_ready", 32'(byteReady), 0);
        checkOutput("reset wr_en", 32'(wrEn), 0);
        checkOutput("reset wr_addr", wrAddr, 32'h0);
        checkOutput("reset wrap wr_addr", wrAddr2, BASE2);
        checkOutput("reset wr_data", wrData, 32'h0);
        checkOutput("reset cpu_hold", 32'(cpuHold), 1);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset err", 32'(err), 0);
        rstN = 1'b0;
        tick();
        checkOutput("idle cpu_hold", 32'(cpuHold), 1);

        $display("[TB] two-word load without stalls");
        applyStimulus(1'b1, 2);
        checkOutput("load busy", 32'(busy), 1);
        checkOutput("load byte_ready", 32'(byteReady), 1);
        checkOutput("load cpu_hold", 32'(cpuHold), 1);
        expectWrite(0, 32'h2008_0005);
        expectWrite(1, 32'hAC01_0004);
        sendWord(32'h2008_0005);
        checkOutput("write latency wr_en", 32'(wrEn), 1);
        checkOutput("write byte_ready", 32'(byteReady), 0);
        sendWord(32'hAC01_0004);
        tick();
        checkOutput("done after load", 32'(done), 1);
        tick();
        checkOutput("done two cycles later", 32'(done), 1);
        checkOutput("done cpu_hold", 32'(cpuHold), 0);
        checkOutput("done busy", 32'(busy), 0);
        checkOutput("done err", 32'(err), 0);

        $display("[TB] bytes offered while not ready");
        byteValid = 1'b1;
        byteData  = 8'hEE;
        tick();
        tick();
        checkOutput("done ignores bytes", 32'(done), 1);
        checkOutput("done byte_ready", 32'(byteReady), 0);
        byteValid = 1'b0;

        $display("[TB] single word with stall");
        applyStimulus(1'b1, 1);
        expectWrite(0, 32'h3C01_1234);
        sendByte(8'h3C);
        sendByte(8'h01);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall byte_ready", 32'(byteReady), 1);
        end
        sendByte(8'h12);
        sendByte(8'h34);
        checkOutput("stall word wr_en", 32'(wrEn), 1);
        tick();
        checkOutput("stall load done", 32'(done), 1);

        $display("[TB] rejected lengths");
        applyStimulus(1'b1, 257);
        checkOutput("overflow done", 32'(done), 1);
        checkOutput("overflow err", 32'(err), 1);
        applyStimulus(1'b1, 0);
        checkOutput("zero len done", 32'(done), 1);
        checkOutput("zero len err", 32'(err), 0);
        checkOutput("zero len cpu_hold", 32'(cpuHold), 0);
        applyStimulus(1'b1, 257);
        checkOutput("overflow again err", 32'(err), 1);

        $display("[TB] start ignored during load");
        applyStimulus(1'b1, 3);
        checkOutput("valid start clears err", 32'(err), 0);
        checkOutput("valid start busy", 32'(busy), 1);
        expectWrite(0, 32'h8C22_0000);
        expectWrite(1, 32'h0022_1820);
        expectWrite(2, 32'hAC23_0008);
        sendByte(8'h8C);
        sendByte(8'h22);
        start = 1'b1;
        len   = 1;
        sendByte(8'h00);
        start = 1'b0;
        sendByte(8'h00);
        sendWord(32'h0022_1820);
        sendWord(32'hAC23_0008);
        tick();
        checkOutput("three-word done", 32'(done), 1);

        $display("[TB] reset mid-load");
        applyStimulus(1'b1, 256);
        checkOutput("max len busy", 32'(busy), 1);
        checkOutput("max len done", 32'(done), 0);
        expectWrite(0, 32'h2402_000A);
        sendWord(32'h2402_000A);
        sendByte(8'h11);
        sendByte(8'h22);
        rstN = 1'b1;
        tick();
        checkOutput("mid reset cpu_hold", 32'(cpuHold), 1);
        checkOutput("mid reset busy", 32'(busy), 0);
        checkOutput("mid reset byte_ready", 32'(byteReady), 0);
        checkOutput("mid reset wr_en", 32'(wrEn), 0);
        checkOutput("mid reset wr_addr", wrAddr, 32'h0);
        checkOutput("mid reset wr_data", wrData, 32'h0);
        rstN = 1'b0;
        tick();
        tick();

        $display("[TB] fresh load, reset during write");
        applyStimulus(1'b1, 1);
        expectWrite(0, 32'h03E0_0008);
        sendWord(32'h03E0_0008);
        checkOutput("fresh write at base", wrAddr, 32'h0);
        rstN = 1'b1;
        tick();
        checkOutput("write reset wr_en", 32'(wrEn), 0);
        checkOutput("write reset done", 32'(done), 0);
        checkOutput("write reset cpu_hold", 32'(cpuHold), 1);
        rstN = 1'b0;
        tick();
        tick();

        checkOutput("scoreboard drained", 32'(q1.size()), 0);
        checkOutput("wrap scoreboard drained", 32'(q2.size()), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning the byte address of the first loaded word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-high reset (asserted when 1, sampled on the rising clk edge).
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port len  input  ADDR_W+1  number of words to load, sampled when start is accepted.
REQ-007 SHALL have port byte_valid  input  1  source has a byte on byte_data.
REQ-008 SHALL have port byte_data  input  8  program byte stream, most significant byte of each word first.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 SHALL have port wr_en  output  1  instruction memory write strobe.
REQ-011 SHALL have port wr_addr  output  32  word-aligned byte address of the write.
REQ-012 SHALL have port wr_data  output  32  assembled instruction word.
REQ-013 SHALL have port cpu_hold  output  1  holds the MIPS core in reset while set.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  load finished; level output.
REQ-016 SHALL have port err  output  1  last start was rejected for length overflow; level output.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, WRITE and DONE.
REQ-018 IDLE SHALL set byte_ready=0, busy=0, done=0 and cpu_hold=1.
REQ-019 In IDLE or DONE, start with 1<=len<=2^ADDR_W SHALL latch len, clear word_idx and byte_cnt, clear err and done, and go to LOAD.
REQ-020 In IDLE or DONE, start with len=0 SHALL go to DONE with err=0, perform no write and leave cpu_hold=0 in DONE.
REQ-021 In IDLE or DONE, start with len>2^ADDR_W SHALL go to DONE with err=1 and perform no write.
REQ-022 LOAD SHALL drive byte_ready=1, busy=1 and cpu_hold=1.
REQ-023 A byte SHALL be accepted only on a cycle where both byte_valid and byte_ready are 1.
REQ-024 In LOAD, accepted bytes SHALL fill the word shift register in order byte_cnt 0 to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
REQ-025 Accepting the fourth byte (byte_cnt=3) SHALL move the FSM to WRITE on the next edge, with byte_cnt wrapping to 0.
REQ-026 WRITE SHALL last exactly one cycle with wr_en=1, wr_addr=BASE+4*word_idx (32-bit wrap), wr_data=the assembled word and byte_ready=0.
REQ-027 wr_en SHALL be 0 in every state other than WRITE.
REQ-028 Write latency SHALL be exactly one cycle from acceptance of a word's fourth byte to wr_en=1.
REQ-029 After WRITE, if word_idx=len-1 the FSM SHALL go to DONE; otherwise it SHALL increment word_idx and return to LOAD.
REQ-030 DONE SHALL set done=1, busy=0, cpu_hold=0 and byte_ready=0, and hold err.
REQ-031 start SHALL be ignored in LOAD and WRITE.
REQ-032 byte_valid while byte_ready=0 SHALL have no effect, and the byte SHALL NOT be consumed.
REQ-033 Stalls (byte_valid=0) in LOAD SHALL be of any length and SHALL preserve the partial word and byte_cnt.

Reset
REQ-034 rst_n=1 at a clock edge SHALL force IDLE with word_idx=0, byte_cnt=0, shift register=0 and latched len=0.
REQ-035 Outputs during and after reset SHALL be byte_ready=0, wr_en=0, wr_addr=BASE, wr_data=0, cpu_hold=1, busy=0, done=0 and err=0.
REQ-036 Reset mid-operation, including in the WRITE cycle, SHALL discard any partial word and suppress wr_en from the following cycle onward.
REQ-037 Reset SHALL take priority over start and over byte acceptance in the same cycle.

Verification
REQ-038 Reset, then start with len=2 and bytes 20,08,00,05,AC,01,00,04 with no stalls -> wr_en pulses with (00000000, 20080005) and (00000004, AC010004); done=1 and cpu_hold=0 two cycles after the last write.
REQ-039 len=1 with byte_valid dropped for 5 cycles after the second byte -> single write of the correct word; byte_ready stays 1 during the stall; no extra write.
REQ-040 With ADDR_W=8, start with len=0 -> DONE next cycle, err=0, no wr_en; start with len=257 -> DONE, err=1, no wr_en.
REQ-041 Second start pulse during LOAD with len=3 -> ignored; exactly 3 writes at 0, 4 and 8.
REQ-042 Reset asserted after 2 bytes of word 1 -> IDLE, cpu_hold=1, no wr_en; a fresh load afterwards writes word 0 at BASE.
REQ-043 BASE=FFFFFFFC, len=2 -> writes at FFFFFFFC and then 00000000 (address wrap).
